// File: rtl/cascade_modn_counter_if.sv
// rtl/cascade_modn_counter_if.sv - control/status bundle for one mod-N counter stage
interface cascade_modn_counter_if #(
    parameter int WIDTH = 4
);
    logic             cin;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] modn;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output cin, up, load, d, modn,
        input  q, tc, ovf
    );

    modport slave (
        input  cin, up, load, d, modn,
        output q, tc, ovf
    );
endinterface

// File: rtl/cascade_modn_counter.sv
// rtl/cascade_modn_counter.sv - cascadable up/down modulo-(modn+1) counter with sticky wrap flag
module cascade_modn_counter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    cascade_modn_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             at_top;
    logic             at_zero;

    assign at_top  = (q_reg >= bus.modn);
    assign at_zero = (q_reg == ZERO);

    // tc is the wrap predicate itself so a downstream stage counts on the same edge
    assign bus.tc  = bus.cin & (bus.up ? at_top : at_zero);
    assign bus.q   = q_reg;
    assign bus.ovf = ovf_reg;

    always_comb begin
        q_next   = q_reg;
        ovf_next = ovf_reg;
        if (bus.load) begin
            q_next   = (bus.d > bus.modn) ? bus.modn : bus.d;
            ovf_next = 1'b0;
        end else if (bus.cin) begin
            if (bus.up) begin
                if (at_top) begin
                    q_next   = ZERO;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_reg + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_next   = bus.modn;
                    ovf_next = 1'b1;
                end else if (q_reg > bus.modn) begin
                    // modn was lowered below the count: snap to the new top, not a wrap
                    q_next = bus.modn;
                end else begin
                    q_next = q_reg - ONE;
                end
            end
        end
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            q_reg   <= ZERO;
            ovf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            ovf_reg <= ovf_next;
        end
    end
endmodule

// File: tb/tb_cascade_modn_counter.sv
// tb/tb_cascade_modn_counter.sv - self-checking bench for cascade_modn_counter
module tb_cascade_modn_counter;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;

    cascade_modn_counter_if #(.WIDTH(WIDTH)) bus_lo ();
    cascade_modn_counter_if #(.WIDTH(WIDTH)) bus_hi ();

    cascade_modn_counter #(.WIDTH(WIDTH)) dut_lo (.clk(clk), .clr(clr), .bus(bus_lo));
    cascade_modn_counter #(.WIDTH(WIDTH)) dut_hi (.clk(clk), .clr(clr), .bus(bus_hi));

    assign bus_hi.cin = bus_lo.tc;
    assign bus_hi.up  = bus_lo.up;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int mq_lo = 0;
    int mq_hi = 0;
    bit mov_lo = 1'b0;
    bit mov_hi = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(input int q, input bit cin, input bit up, input int modn);
        if (!cin) return 1'b0;
        return up ? (q >= modn) : (q == 0);
    endfunction

    // Counting is arithmetic modulo (modn+1); a count left above modn is handled separately
    function automatic void model_step(input bit ld, input bit cin, input bit up,
                                       input int d, input int modn,
                                       inout int q, inout bit ov);
        int n;
        n = modn + 1;
        if (ld) begin
            q  = (d < modn) ? d : modn;
            ov = 1'b0;
        end else if (cin) begin
            if (up) begin
                if (q > modn) begin
                    q  = 0;
                    ov = 1'b1;
                end else begin
                    q = (q + 1) % n;
                    if (q == 0) ov = 1'b1;
                end
            end else begin
                if (q > modn) begin
                    q = modn;
                end else begin
                    if (q == 0) ov = 1'b1;
                    q = (q + n - 1) % n;
                end
            end
        end
    endfunction

    always @(negedge clk) begin : model_update
        bit hc;
        if (clr) begin
            hc = model_tc(mq_lo, bus_lo.cin, bus_lo.up, int'(bus_lo.modn));
            model_step(bus_lo.load, bus_lo.cin, bus_lo.up, int'(bus_lo.d), int'(bus_lo.modn),
                       mq_lo, mov_lo);
            model_step(bus_hi.load, hc, bus_lo.up, int'(bus_hi.d), int'(bus_hi.modn),
                       mq_hi, mov_hi);
        end
    end

    always @(negedge clr) begin
        mq_lo  = 0;
        mq_hi  = 0;
        mov_lo = 1'b0;
        mov_hi = 1'b0;
    end

    always @(posedge clk) begin : compare
        bit hc;
        hc = model_tc(mq_lo, bus_lo.cin, bus_lo.up, int'(bus_lo.modn));
        chk("q_lo",   int'(bus_lo.q),   mq_lo);
        chk("ovf_lo", int'(bus_lo.ovf), int'(mov_lo));
        chk("tc_lo",  int'(bus_lo.tc),  int'(hc));
        chk("q_hi",   int'(bus_hi.q),   mq_hi);
        chk("ovf_hi", int'(bus_hi.ovf), int'(mov_hi));
        chk("tc_hi",  int'(bus_hi.tc),  int'(model_tc(mq_hi, hc, bus_lo.up, int'(bus_hi.modn))));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn[4]  = '{1, 0, 5, 4};
    int cin_pat[4] = '{1, 0, 1, 0};
    int exp_en[4]  = '{8, 8, 9, 9};

    initial begin
        bus_lo.cin  = 1'b1;
        bus_lo.up   = 1'b1;
        bus_lo.load = 1'b1;
        bus_lo.d    = 4'd3;
        bus_lo.modn = 4'd0;
        bus_hi.load = 1'b0;
        bus_hi.d    = 4'd0;
        bus_hi.modn = 4'd9;

        // reset holds q/ovf at zero, ignores load/cin; with modn=0 tc follows cin
        step();
        step();
        chk("rst_q",   int'(bus_lo.q),   0);
        chk("rst_ovf", int'(bus_lo.ovf), 0);
        chk("rst_tc",  int'(bus_lo.tc),  1);
        clr = 1'b1;

        // up wrap at modn=9
        bus_lo.load = 1'b0;
        bus_lo.modn = 4'd9;
        clr_pulse();
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_q",   int'(bus_lo.q),   exp_up[i]);
            chk("up_tc",  int'(bus_lo.tc),  (exp_up[i] == 9) ? 1 : 0);
            chk("up_ovf", int'(bus_lo.ovf), (i >= 9) ? 1 : 0);
        end

        // down wrap from a loaded value
        bus_lo.load = 1'b1;
        bus_lo.cin  = 1'b0;
        bus_lo.d    = 4'd2;
        bus_lo.modn = 4'd5;
        bus_lo.up   = 1'b0;
        step();
        chk("dn_load_q", int'(bus_lo.q), 2);
        bus_lo.load = 1'b0;
        bus_lo.cin  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dn_q",   int'(bus_lo.q),   exp_dn[i]);
            chk("dn_tc",  int'(bus_lo.tc),  (exp_dn[i] == 0) ? 1 : 0);
            chk("dn_ovf", int'(bus_lo.ovf), (i >= 2) ? 1 : 0);
        end

        // load wins over cin and clamps to modn, clearing the sticky flag
        bus_lo.load = 1'b1;
        bus_lo.d    = 4'd12;
        bus_lo.modn = 4'd7;
        bus_lo.up   = 1'b1;
        step();
        chk("clamp_q",   int'(bus_lo.q),   7);
        chk("clamp_ovf", int'(bus_lo.ovf), 0);

        // enable gating with full range
        bus_lo.load = 1'b0;
        bus_lo.modn = 4'd15;
        for (int i = 0; i < 4; i++) begin
            bus_lo.cin = cin_pat[i][0];
            step();
            chk("en_q",   int'(bus_lo.q),   exp_en[i]);
            chk("en_ovf", int'(bus_lo.ovf), 0);
        end

        // modn lowered below the count while counting up
        bus_lo.load = 1'b1;
        bus_lo.d    = 4'd6;
        bus_lo.modn = 4'd9;
        step();
        bus_lo.load = 1'b0;
        bus_lo.cin  = 1'b1;
        bus_lo.modn = 4'd3;
        step();
        chk("lower_q",   int'(bus_lo.q),   0);
        chk("lower_ovf", int'(bus_lo.ovf), 1);

        // modn=0: q pinned at 0, first count sets ovf, tc equals cin
        bus_lo.load = 1'b1;
        bus_lo.d    = 4'd5;
        bus_lo.modn = 4'd0;
        step();
        chk("m0_load_q", int'(bus_lo.q), 0);
        bus_lo.load = 1'b0;
        step();
        chk("m0_q",   int'(bus_lo.q),   0);
        chk("m0_ovf", int'(bus_lo.ovf), 1);
        chk("m0_tc",  int'(bus_lo.tc),  1);

        // clr mid-count acts before the next edge
        bus_lo.modn = 4'd9;
        step();
        step();
        clr = 1'b0;
        #2;
        chk("aclr_q",   int'(bus_lo.q),   0);
        chk("aclr_ovf", int'(bus_lo.ovf), 0);
        step();
        chk("aclr_hold_q", int'(bus_lo.q), 0);
        clr = 1'b1;

        // two-stage decade cascade reaches 20
        bus_lo.up   = 1'b1;
        bus_lo.cin  = 1'b1;
        bus_lo.modn = 4'd9;
        clr_pulse();
        for (int i = 0; i < 20; i++) step();
        chk("cascade_val", int'(bus_hi.q) * 10 + int'(bus_lo.q), 20);
        chk("cascade_hi_ovf", int'(bus_hi.ovf), 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus_lo.cin  = ($urandom_range(0, 9) < 7);
            bus_lo.up   = $urandom_range(0, 1) == 1;
            bus_lo.load = ($urandom_range(0, 9) == 0);
            bus_lo.d    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) bus_lo.modn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) clr = 1'b0;
            else clr = 1'b1;
            step();
        end
        clr = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
